// File: rtl/fp_minmax_scanner_pkg.sv
// Shared constants for the min/max scanner: data width, scanner states and mode encodings.
package fp_minmax_scanner_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/fp_comparator.sv
// Combinational ordering of two floating-point words by raw sign-magnitude bit pattern.
// Equal patterns raise neither flag; +0 orders above -0.
module fp_comparator
  import fp_minmax_scanner_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  a_gt_b,
  output logic                  b_gt_a
);

  logic                  a_sign;
  logic                  b_sign;
  logic [DATA_WIDTH-2:0] a_mag;
  logic [DATA_WIDTH-2:0] b_mag;

  assign a_sign = a[DATA_WIDTH-1];
  assign b_sign = b[DATA_WIDTH-1];
  assign a_mag  = a[DATA_WIDTH-2:0];
  assign b_mag  = b[DATA_WIDTH-2:0];

  always_comb begin
    a_gt_b = 1'b0;
    b_gt_a = 1'b0;
    if (a_sign != b_sign) begin
      a_gt_b = !a_sign;
      b_gt_a = a_sign;
    end else if (!a_sign) begin
      a_gt_b = (a_mag > b_mag);
      b_gt_a = (b_mag > a_mag);
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      a_gt_b = (a_mag < b_mag);
      b_gt_a = (b_mag < a_mag);
    end
  end

endmodule

// File: rtl/fp_minmax_scanner_chk.sv
// Simulation-only protocol checks for the scanner: a start must never request more than MAX_COUNT elements.
module fp_minmax_scanner_chk #(
  parameter int MAX_COUNT = 256,
  parameter int IDX_W     = $clog2(MAX_COUNT)
) (
  input logic           clk,
  input logic           rst,
  input logic           start,
  input logic           idle,
  input logic [IDX_W:0] count
);

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_COUNT);

  a_count_legal: assert property (@(posedge clk) disable iff (rst)
    (start && idle) |-> (count <= MAX_CNT));

endmodule

// File: rtl/fp_minmax_scanner.sv
// Streams a block of floating-point words through one fp_comparator and returns the
// max or min value together with the index of its first occurrence.
module fp_minmax_scanner
  import fp_minmax_scanner_pkg::*;
#(
  parameter int MAX_COUNT = 256,
  parameter int IDX_W     = $clog2(MAX_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [IDX_W:0]        count,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_empty,
  output logic                  busy
);

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_COUNT);

  scan_state_e           state_q, state_d;
  logic                  mode_q, mode_d;
  logic [IDX_W:0]        count_q, count_d;
  logic [IDX_W:0]        elem_cnt_q, elem_cnt_d;
  logic [DATA_WIDTH-1:0] best_value_q, best_value_d;
  logic [IDX_W-1:0]      best_index_q, best_index_d;
  logic                  out_empty_q, out_empty_d;

  logic                  a_gt_b;
  logic                  b_gt_a;
  logic                  accept;
  logic                  replace;
  logic                  last_elem;
  logic [IDX_W:0]        count_sat;

  fp_comparator u_cmp (
    .a      (in_data),
    .b      (best_value_q),
    .a_gt_b (a_gt_b),
    .b_gt_a (b_gt_a)
  );

  fp_minmax_scanner_chk #(.MAX_COUNT(MAX_COUNT), .IDX_W(IDX_W)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .idle  (state_q == IDLE),
    .count (count)
  );

  assign count_sat = (count > MAX_CNT) ? MAX_CNT : count;
  assign accept    = (state_q == SCAN) && in_valid;
  assign replace   = (mode_q == MODE_MAX) ? a_gt_b : b_gt_a;
  assign last_elem = (elem_cnt_q == (count_q - (IDX_W+1)'(1)));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    count_d      = count_q;
    elem_cnt_d   = elem_cnt_q;
    best_value_d = best_value_q;
    best_index_d = best_index_q;
    out_empty_d  = out_empty_q;
    case (state_q)
      IDLE: begin
        // Abort outranks start even though it has no other effect in IDLE.
        if (start && !abort) begin
          best_value_d = '0;
          best_index_d = '0;
          if (count == '0) begin
            out_empty_d = 1'b1;
            state_d     = DONE;
          end else begin
            mode_d     = mode;
            count_d    = count_sat;
            elem_cnt_d = '0;
            state_d    = SCAN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          if ((elem_cnt_q == '0) || replace) begin
            best_value_d = in_data;
            best_index_d = elem_cnt_q[IDX_W-1:0];
          end else begin
            best_value_d = best_value_q;
          end
          elem_cnt_d = elem_cnt_q + (IDX_W+1)'(1);
          state_d    = last_elem ? DONE : SCAN;
        end else begin
          state_d = SCAN;
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          out_empty_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= MODE_MAX;
      count_q      <= '0;
      elem_cnt_q   <= '0;
      best_value_q <= '0;
      best_index_q <= '0;
      out_empty_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      count_q      <= count_d;
      elem_cnt_q   <= elem_cnt_d;
      best_value_q <= best_value_d;
      best_index_q <= best_index_d;
      out_empty_q  <= out_empty_d;
    end
  end

  assign in_ready  = (state_q == SCAN);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_value = best_value_q;
  assign out_index = best_index_q;
  assign out_empty = out_empty_q;

endmodule

// File: tb/tb_fp_minmax_scanner.sv
// Self-checking bench for fp_minmax_scanner: directed plan cases plus randomized scans
// checked against a value-ordering reference model.
module tb_fp_minmax_scanner;
  import fp_minmax_scanner_pkg::*;

  localparam int MAXC = 256;
  localparam int IW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, mode, abort, in_valid, out_ready;
  logic [IW:0]   count;
  logic [31:0]   in_data;
  logic          in_ready, out_valid, out_empty, busy;
  logic [31:0]   out_value;
  logic [IW-1:0] out_index;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] stim[$];

  fp_minmax_scanner #(.MAX_COUNT(MAXC), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .count(count), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_index(out_index), .out_empty(out_empty), .busy(busy)
  );

  always #5 clk = ~clk;

  // Total order on values: sign-magnitude mapped onto integers, -0 just below +0.
  function automatic longint fkey(input logic [31:0] v);
    return v[31] ? (-longint'(v[30:0]) - 64'sd1) : longint'(v[30:0]);
  endfunction

  function automatic void ref_result(input bit m, output logic [31:0] val, output int idx);
    idx = 0;
    val = stim[0];
    for (int i = 1; i < stim.size(); i++) begin
      if (m ? (fkey(stim[i]) < fkey(val)) : (fkey(stim[i]) > fkey(val))) begin
        val = stim[i];
        idx = i;
      end
    end
  endfunction

  task automatic launch(input bit m, input int n);
    @(negedge clk);
    start = 1'b1; mode = m; count = n[IW:0];
    @(posedge clk);
    #1;
    start = 1'b0; mode = 1'($urandom); count = 9'($urandom_range(0, 256));
  endtask

  // Feeds stim until out_valid; pct<0 toggles in_valid every cycle. lat counts edges from start.
  task automatic feed(input int pct, output int lat, output bit tmo);
    int  idx;
    bit  rdy;
    idx = 0; lat = 1; tmo = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        tmo = 1'b0;
        break;
      end
      if (pct < 0) in_valid = (cyc % 2 == 0) && (idx < stim.size());
      else         in_valid = (idx < stim.size()) && (int'($urandom_range(99)) < pct);
      in_data = (idx < stim.size()) ? stim[idx] : $urandom;
      rdy = in_ready;
      @(posedge clk);
      if (rdy && in_valid) idx++;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; count = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({in_ready, out_valid, out_empty, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {in_ready, out_valid, out_empty, busy}); end
    n_checks++; if (out_value !== 32'h0 || out_index !== 8'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%0d want 0/0", out_value, out_index); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [31:0] d[4][4] = '{
      '{32'h3F800000, 32'h40400000, 32'hC0000000, 32'h40000000},
      '{32'h3F800000, 32'h40400000, 32'hC0000000, 32'h40000000},
      '{32'h40000000, 32'h40A00000, 32'h40A00000, 32'h3F800000},
      '{32'h80000000, 32'h00000000, 32'h0, 32'h0}};
    bit          md[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int          nn[4] = '{4, 4, 4, 2};
    logic [31:0] ev[4] = '{32'h40400000, 32'hC0000000, 32'h40A00000, 32'h00000000};
    int          ei[4] = '{1, 2, 1, 1};
    int lat; bit tmo; logic [31:0] mv; int mi;
    for (int c = 0; c < 4; c++) begin
      stim.delete();
      for (int i = 0; i < nn[c]; i++) stim.push_back(d[c][i]);
      ref_result(md[c], mv, mi);
      launch(md[c], nn[c]);
      feed(100, lat, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL dir_timeout case %0d: out_valid never seen", c); end
      n_checks++; if (out_value !== ev[c] || mv !== ev[c]) begin
        n_fail++; $display("FAIL dir_value case %0d: got %h model %h want %h", c, out_value, mv, ev[c]); end
      n_checks++; if (out_index !== ei[c][7:0] || mi != ei[c]) begin
        n_fail++; $display("FAIL dir_index case %0d: got %0d model %0d want %0d", c, out_index, mi, ei[c]); end
      n_checks++; if (lat != nn[c] + 1) begin
        n_fail++; $display("FAIL dir_latency case %0d: got %0d want %0d", c, lat, nn[c] + 1); end
      n_checks++; if (out_empty !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL dir_done_flags case %0d: got %b%b%b want 010", c, out_empty, busy, in_ready); end
      release_result();
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL dir_release case %0d: got valid %b busy %b want 0 0", c, out_valid, busy); end
    end
  endtask

  task automatic test_backpressure();
    int lat; bit tmo; logic [31:0] mv; int mi;
    logic [31:0] hv; logic [IW-1:0] hi;
    stim.delete();
    stim.push_back(32'hC1200000); stim.push_back(32'h41100000); stim.push_back(32'h41100000);
    ref_result(1'b0, mv, mi);
    launch(1'b0, 3);
    feed(-1, lat, tmo);
    n_checks++; if (tmo !== 1'b0 || out_value !== mv || out_index !== mi[7:0]) begin
      n_fail++; $display("FAIL bp_toggle: got %h/%0d tmo %b want %h/%0d", out_value, out_index, tmo, mv, mi); end
    n_checks++; if (lat <= 4) begin n_fail++; $display("FAIL bp_lat: got %0d want >4", lat); end
    hv = out_value; hi = out_index;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin start = 1'b1; count = '0; end
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_value !== hv || out_index !== hi || out_empty !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cyc %0d: got %b %h/%0d e%b want 1 %h/%0d e0", k, out_valid, out_value, out_index, out_empty, hv, hi); end
    end
    release_result();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_count_zero();
    launch(1'b1, 0);
    @(negedge clk);
    n_checks++; if ({out_valid, out_empty, busy, in_ready} !== 4'b1110) begin
      n_fail++; $display("FAIL zero_flags: got %b want 1110", {out_valid, out_empty, busy, in_ready}); end
    n_checks++; if (out_value !== 32'h0 || out_index !== 8'h0) begin
      n_fail++; $display("FAIL zero_data: got %h/%0d want 0/0", out_value, out_index); end
    release_result();
    @(negedge clk);
    n_checks++; if (out_empty !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_clear: got empty %b valid %b want 0 0", out_empty, out_valid); end
  endtask

  task automatic test_abort();
    bit seen;
    launch(1'b0, 4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 32'h3F800000 + i;
      @(posedge clk);
    end
    @(negedge clk); abort = 1'b1; in_valid = 1'b1; in_data = 32'h7F000000;
    @(posedge clk); #1; abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy, in_ready, out_valid} !== 3'b000) begin
      n_fail++; $display("FAIL abort_idle: got %b want 000", {busy, in_ready, out_valid}); end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_result: got out_valid 1 want 0"); end
    @(negedge clk); start = 1'b1; abort = 1'b1; count = 9'd3;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_over_start: got busy %b want 0", busy); end
  endtask

  task automatic test_random();
    int lat; bit tmo; logic [31:0] mv; int mi; bit m; int n;
    logic [31:0] pool[8] = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000,
                             32'h7FC00000, 32'hFFC00000, 32'h3F800000, 32'hBF800000};
    for (int it = 0; it < 40; it++) begin
      m = 1'($urandom);
      n = (it == 39) ? MAXC : int'($urandom_range(1, 12));
      stim.delete();
      for (int i = 0; i < n; i++)
        stim.push_back(($urandom_range(1) == 0) ? pool[$urandom_range(7)] : $urandom);
      ref_result(m, mv, mi);
      launch(m, n);
      feed((it == 39) ? 100 : int'($urandom_range(30, 100)), lat, tmo);
      n_checks++; if (tmo !== 1'b0 || out_value !== mv || out_index !== mi[7:0] || out_empty !== 1'b0) begin
        n_fail++; $display("FAIL rand it %0d m %0d n %0d: got %h/%0d e%b tmo %b want %h/%0d",
                           it, m, n, out_value, out_index, out_empty, tmo, mv, mi); end
      if (it == 39) begin
        n_checks++; if (lat != MAXC + 1) begin n_fail++; $display("FAIL rand_full_lat: got %0d want %0d", lat, MAXC + 1); end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result();
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid_scan();
    launch(1'b0, 4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 32'h42000000 + i;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if ({in_ready, out_valid, out_empty, busy} !== 4'b0000 || out_value !== 32'h0 || out_index !== 8'h0) begin
      n_fail++; $display("FAIL rst_mid: got %b %h/%0d want 0000 0/0", {in_ready, out_valid, out_empty, busy}, out_value, out_index); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_after: got busy %b valid %b want 0 0", busy, out_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_count_zero();
    test_abort();
    test_random();
    test_rst_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
